// File: rtl/psram_pkg.sv
// Shared command codes, FSM state and ID-byte defaults for the SPI PSRAM responder.
package psram_pkg;

    localparam logic [7:0] CMD_WRITE   = 8'h02;
    localparam logic [7:0] CMD_READ    = 8'h03;
    localparam logic [7:0] CMD_READ_ID = 8'h9F;
    localparam logic [7:0] CMD_RST_EN  = 8'h66;
    localparam logic [7:0] CMD_RST     = 8'h99;

    localparam logic [7:0] MFID_DEF = 8'h0D;
    localparam logic [7:0] KGD_DEF  = 8'h5D;
    localparam logic [7:0] EID_DEF  = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

    typedef enum logic [1:0] {
        MODE_WRITE,
        MODE_READ,
        MODE_ID
    } mode_t;

endpackage

// File: rtl/psram_spi_sync.sv
// 2-FF synchronizers for ce_n/clk/si plus clk edge detect on sys_clk.
// Equal 2-cycle latency on all three pins keeps edges aligned; no backpressure.
module psram_spi_sync (
    input  logic sys_clk,
    input  logic sys_reset_n,
    input  logic i_ce_n,
    input  logic i_clk,
    input  logic i_si,
    output logic o_ce_n_s,
    output logic o_si_s,
    output logic o_rise,
    output logic o_fall
);

    logic [1:0] r_ce_n_sync;
    logic [1:0] r_clk_sync;
    logic [1:0] r_si_sync;
    logic       r_clk_d;

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_ce_n_sync <= 2'b11;
            r_clk_sync  <= 2'b00;
            r_si_sync   <= 2'b00;
            r_clk_d     <= 1'b0;
        end else begin
            r_ce_n_sync <= {r_ce_n_sync[0], i_ce_n};
            r_clk_sync  <= {r_clk_sync[0], i_clk};
            r_si_sync   <= {r_si_sync[0], i_si};
            r_clk_d     <= r_clk_sync[1];
        end
    end

    assign o_ce_n_s = r_ce_n_sync[1];
    assign o_si_s   = r_si_sync[1];
    assign o_rise   = r_clk_sync[1] & ~r_clk_d;
    assign o_fall   = ~r_clk_sync[1] & r_clk_d;

endmodule

// File: rtl/psram_responder.sv
// Serial PSRAM responder: oversampled SPI mode-0 target (write/read/read-ID/reset) over a byte RAM.
// so updates within 3 sys_clk of a clk fall; no backpressure, the initiator paces everything via clk.
module psram_responder
    import psram_pkg::*;
#(
    parameter int         ADDR_BITS = 10,
    parameter logic [7:0] MFID      = MFID_DEF,
    parameter logic [7:0] KGD       = KGD_DEF,
    parameter logic [7:0] EID       = EID_DEF
) (
    input  logic sys_clk,
    input  logic sys_reset_n,
    input  logic ce_n,
    input  logic clk,
    input  logic si,
    output logic so,
    output logic so_oe,
    output logic soft_reset,
    output logic busy
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic w_ce_n_s;
    logic w_si_s;
    logic w_rise;
    logic w_fall;

    psram_spi_sync u_sync (
        .sys_clk     (sys_clk),
        .sys_reset_n (sys_reset_n),
        .i_ce_n      (ce_n),
        .i_clk       (clk),
        .i_si        (si),
        .o_ce_n_s    (w_ce_n_s),
        .o_si_s      (w_si_s),
        .o_rise      (w_rise),
        .o_fall      (w_fall)
    );

    state_t               r_state;
    state_t               w_state_nxt;
    mode_t                r_mode;
    logic [2:0]           r_bit_cnt;
    logic [1:0]           r_byte_cnt;
    logic [6:0]           r_shift_in;
    logic [7:0]           r_shift_out;
    logic [ADDR_BITS-1:0] r_addr;
    logic                 r_rst_en;
    logic                 r_id_eid;
    logic                 r_load_pend;
    logic                 r_so;
    logic                 r_so_oe;
    logic                 r_soft_reset;
    logic [7:0]           r_mem [DEPTH];
    logic [7:0]           r_mem_q;

    logic [7:0]           w_byte_in;
    logic                 w_byte_done;
    logic [ADDR_BITS-1:0] w_addr_shift;
    logic [ADDR_BITS-1:0] w_addr_inc;
    logic [ADDR_BITS-1:0] w_mem_addr;
    logic                 w_cmd_done;
    logic                 w_addr_byte;
    logic                 w_addr_done;
    logic                 w_mem_we;
    logic                 w_rd_next;
    logic                 w_drive;

    assign w_byte_in    = {r_shift_in, w_si_s};
    assign w_byte_done  = w_rise && (r_bit_cnt == 3'd7);
    // Only the low ADDR_BITS of the 24-bit address survive the three shifts.
    assign w_addr_shift = ADDR_BITS'({r_addr, w_byte_in});
    assign w_addr_inc   = r_addr + ADDR_BITS'(1);

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) r_state <= ST_IDLE;
        else              r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_ce_n_s) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_CMD;
                ST_CMD: begin
                    if (w_byte_done) begin
                        if (w_byte_in == CMD_WRITE || w_byte_in == CMD_READ ||
                            w_byte_in == CMD_READ_ID)
                            w_state_nxt = ST_ADDR;
                        else
                            w_state_nxt = ST_IGNORE;
                    end
                end
                ST_ADDR: begin
                    if (w_byte_done && r_byte_cnt == 2'd2)
                        w_state_nxt = (r_mode == MODE_WRITE) ? ST_WDATA : ST_RDATA;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Deselect gates every strobe, so a byte finishing as ce_n rises is dropped.
    always_comb begin
        w_cmd_done  = 1'b0;
        w_addr_byte = 1'b0;
        w_addr_done = 1'b0;
        w_mem_we    = 1'b0;
        w_rd_next   = 1'b0;
        w_drive     = 1'b0;
        w_mem_addr  = r_addr;
        if (!w_ce_n_s) begin
            case (r_state)
                ST_CMD: w_cmd_done = w_byte_done;
                ST_ADDR: begin
                    w_addr_byte = w_byte_done;
                    w_addr_done = w_byte_done && (r_byte_cnt == 2'd2);
                    w_mem_addr  = w_addr_shift;
                end
                ST_WDATA: w_mem_we = w_byte_done;
                ST_RDATA: begin
                    w_rd_next  = w_byte_done;
                    w_drive    = w_fall;
                    w_mem_addr = w_addr_inc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_mode       <= MODE_WRITE;
            r_bit_cnt    <= 3'd0;
            r_byte_cnt   <= 2'd0;
            r_shift_in   <= 7'd0;
            r_shift_out  <= 8'd0;
            r_addr       <= '0;
            r_rst_en     <= 1'b0;
            r_id_eid     <= 1'b0;
            r_load_pend  <= 1'b0;
            r_so         <= 1'b0;
            r_so_oe      <= 1'b0;
            r_soft_reset <= 1'b0;
        end else begin
            r_soft_reset <= 1'b0;
            r_load_pend  <= 1'b0;
            if (w_ce_n_s) begin
                r_bit_cnt  <= 3'd0;
                r_byte_cnt <= 2'd0;
                r_so       <= 1'b0;
                r_so_oe    <= 1'b0;
            end else begin
                if (w_rise && r_state != ST_IDLE) begin
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    r_shift_in <= w_byte_in[6:0];
                end
                if (w_cmd_done) begin
                    r_rst_en     <= (w_byte_in == CMD_RST_EN);
                    r_soft_reset <= (w_byte_in == CMD_RST) && r_rst_en;
                    if (w_byte_in == CMD_WRITE)        r_mode <= MODE_WRITE;
                    else if (w_byte_in == CMD_READ)    r_mode <= MODE_READ;
                    else if (w_byte_in == CMD_READ_ID) r_mode <= MODE_ID;
                end
                if (w_addr_byte) begin
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    r_addr     <= w_addr_shift;
                end
                if (w_addr_done) begin
                    if (r_mode == MODE_ID) begin
                        r_shift_out <= MFID;
                        r_id_eid    <= 1'b0;
                    end else begin
                        r_load_pend <= 1'b1;
                    end
                end
                if (w_mem_we) r_addr <= w_addr_inc;
                if (w_rd_next) begin
                    if (r_mode == MODE_ID) begin
                        r_shift_out <= r_id_eid ? EID : KGD;
                        r_id_eid    <= 1'b1;
                    end else begin
                        r_addr      <= w_addr_inc;
                        r_load_pend <= 1'b1;
                    end
                end
                if (r_load_pend) r_shift_out <= r_mem_q;
                if (w_drive) begin
                    r_so        <= r_shift_out[7];
                    r_shift_out <= {r_shift_out[6:0], 1'b0};
                    r_so_oe     <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_byte_in;
        r_mem_q <= r_mem[w_mem_addr];
    end

    assign so         = r_so;
    assign so_oe      = r_so_oe;
    assign soft_reset = r_soft_reset;
    assign busy       = ~w_ce_n_s;

endmodule

// File: tb/tb_psram_responder.sv
// Directed + randomized frames against a byte-array model of the responder's memory and ID rules.
module tb_psram_responder;

    localparam int HALF = 40;
    localparam int MASK = 1023;

    logic sys_clk = 1'b0;
    logic sys_reset_n;
    logic ce_n;
    logic clk;
    logic si;
    logic so;
    logic so_oe;
    logic soft_reset;
    logic busy;

    psram_responder dut (
        .sys_clk     (sys_clk),
        .sys_reset_n (sys_reset_n),
        .ce_n        (ce_n),
        .clk         (clk),
        .si          (si),
        .so          (so),
        .so_oe       (so_oe),
        .soft_reset  (soft_reset),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_pass = 0;
    int n_total = 0;
    int sr_cycles = 0;

    always @(negedge sys_clk) if (soft_reset === 1'b1) sr_cycles++;

    logic [7:0] tx [16];
    logic [7:0] rx [16];
    bit         oe_all [16];
    bit         oe_any [16];
    logic [7:0] model_mem [1024];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // nb bytes from tx; the last one is cut to last_bits; hold keeps ce_n low at the end.
    task automatic frame(input int nb, input int last_bits, input bit hold);
        ce_n = 1'b0;
        #HALF;
        for (int i = 0; i < nb; i++) begin
            int nbits;
            nbits = (i == nb - 1) ? last_bits : 8;
            rx[i] = 8'h00;
            oe_all[i] = 1'b1;
            oe_any[i] = 1'b0;
            for (int b = 0; b < nbits; b++) begin
                si = tx[i][7-b];
                #HALF;
                rx[i][7-b] = so;
                if (so_oe !== 1'b1) oe_all[i] = 1'b0;
                if (so_oe === 1'b1) oe_any[i] = 1'b1;
                clk = 1'b1;
                #HALF;
                clk = 1'b0;
            end
        end
        #HALF;
        if (!hold) begin
            ce_n = 1'b1;
            si = 1'b0;
            #(HALF * 2);
        end
    endtask

    task automatic put_cmd(input logic [7:0] cmd, input logic [23:0] a);
        tx[0] = cmd;
        tx[1] = a[23:16];
        tx[2] = a[15:8];
        tx[3] = a[7:0];
    endtask

    // Data must already be in tx[4 +: n].
    task automatic do_write(input logic [23:0] a, input int n);
        put_cmd(8'h02, a);
        frame(4 + n, 8, 1'b0);
        for (int i = 0; i < n; i++) model_mem[(int'(a[9:0]) + i) & MASK] = tx[4 + i];
    endtask

    task automatic do_read(input logic [23:0] a, input int n, input string tag);
        put_cmd(8'h03, a);
        for (int i = 0; i < n; i++) tx[4 + i] = 8'h00;
        frame(4 + n, 8, 1'b0);
        chk({tag, "_oe_addr"}, 32'(oe_any[3]), 32'd0);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, 32'(rx[4 + i]), 32'(model_mem[(int'(a[9:0]) + i) & MASK]));
            chk({tag, "_oe_data"}, 32'(oe_all[4 + i]), 32'd1);
        end
        chk({tag, "_oe_after"}, 32'(so_oe), 32'd0);
    endtask

    initial begin
        bit         exp_bits [8];
        logic [7:0] saved;
        logic [23:0] ra;
        int         rl;
        int         sr0;

        exp_bits = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        ce_n = 1'b1;
        clk = 1'b0;
        si = 1'b0;
        sys_reset_n = 1'b0;
        #33;
        chk("rst_so", 32'(so), 32'd0);
        chk("rst_so_oe", 32'(so_oe), 32'd0);
        chk("rst_soft_reset", 32'(soft_reset), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        sys_reset_n = 1'b1;
        #HALF;

        // Address 0x70F0FE maps to 0x0FE with a 10-bit array.
        tx[4] = 8'h66;
        do_write(24'h70F0FE, 1);
        do_read(24'h70F0FE, 1, "rd66");
        for (int b = 0; b < 8; b++) chk("rd66_bit", 32'(rx[4][7-b]), 32'(exp_bits[b]));

        put_cmd(8'h9F, 24'hFFFFFF);
        for (int i = 4; i < 7; i++) tx[i] = 8'h00;
        frame(7, 8, 1'b0);
        chk("id_mfid", 32'(rx[4]), 32'h0D);
        chk("id_kgd", 32'(rx[5]), 32'h5D);
        chk("id_eid", 32'(rx[6]), 32'h00);
        chk("id_oe", 32'(oe_all[4] & oe_all[5] & oe_all[6]), 32'd1);
        chk("id_oe_cmd", 32'(oe_any[0] | oe_any[3]), 32'd0);

        sr0 = sr_cycles;
        tx[0] = 8'h66; frame(1, 8, 1'b0);
        tx[0] = 8'h99; frame(1, 8, 1'b0);
        #50;
        chk("srst_pulse", 32'(sr_cycles - sr0), 32'd1);
        sr0 = sr_cycles;
        tx[0] = 8'h99; frame(1, 8, 1'b0);
        #50;
        chk("srst_alone", 32'(sr_cycles - sr0), 32'd0);
        sr0 = sr_cycles;
        tx[0] = 8'h66; frame(1, 8, 1'b0);
        put_cmd(8'h03, 24'h0); tx[4] = 8'h00; frame(5, 8, 1'b0);
        tx[0] = 8'h99; frame(1, 8, 1'b0);
        #50;
        chk("srst_interrupted", 32'(sr_cycles - sr0), 32'd0);

        tx[4] = 8'hAA; tx[5] = 8'hBB; tx[6] = 8'hCC;
        do_write(24'h0003FE, 3);
        do_read(24'h0003FF, 2, "wrap");
        chk("wrap_bb", 32'(rx[4]), 32'hBB);
        chk("wrap_cc", 32'(rx[5]), 32'hCC);
        do_read(24'h0003FE, 3, "wrap3");

        tx[4] = 8'($urandom);
        do_write(24'h000010, 1);
        saved = model_mem[16];
        put_cmd(8'h02, 24'h000010);
        tx[4] = ~saved;
        frame(5, 5, 1'b0);
        do_read(24'h000010, 1, "partial");
        chk("partial_kept", 32'(rx[4]), 32'(saved));

        for (int it = 0; it < 6; it++) begin
            ra = 24'($urandom);
            rl = $urandom_range(1, 4);
            for (int i = 0; i < rl; i++) tx[4 + i] = 8'($urandom);
            do_write(ra, rl);
            do_read(ra, rl, "rand");
        end

        put_cmd(8'h03, 24'h0000FE);
        tx[4] = 8'h00; tx[5] = 8'h00;
        frame(6, 3, 1'b1);
        chk("midread_oe", 32'(so_oe), 32'd1);
        sys_reset_n = 1'b0;
        #2;
        chk("midrst_so", 32'(so), 32'd0);
        chk("midrst_so_oe", 32'(so_oe), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        ce_n = 1'b1;
        #HALF;
        sys_reset_n = 1'b1;
        #(HALF * 2);
        do_read(24'h0000FE, 1, "postrst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
